// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the
// forwarding logic that reuses its hazard detector.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs of the stall/flush controller.
// The datapath side uses master; the controller uses slave.
interface pipeline_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 ex_branch_valid;
    logic                 ex_predict_jump;
    logic                 ex_actual_jump;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 halt_req;

    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_en;
    logic                 ex_mem_en;
    logic                 mem_wb_en;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 redirect;
    logic                 halted;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
               ex_branch_valid, ex_predict_jump, ex_actual_jump,
               mem_req, mem_ready, halt_req,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, redirect, halted, mem_timeout,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
               ex_branch_valid, ex_predict_jump, ex_actual_jump,
               mem_req, mem_ready, halt_req,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, redirect, halted, mem_timeout,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the ID instruction reads a register that
// the load currently in EX has not yet produced.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    // x0 is never really written, so a load to it cannot create a dependency
    assign load_use = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: drives pipeline-register enables/flushes,
// tracks data-memory waits with a timeout, and keeps saturating perf counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT  = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave ctl
);
    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    ctrl_state_t          state, state_nxt;
    logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    logic load_use, mispredict, mem_stall, apply_run;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, redirect, halted, mem_timeout;

    hazard_detect u_hazard (
        .id_rs1      (ctl.id_rs1),
        .id_rs2      (ctl.id_rs2),
        .id_rs1_used (ctl.id_rs1_used),
        .id_rs2_used (ctl.id_rs2_used),
        .ex_mem_read (ctl.ex_mem_read),
        .ex_rd       (ctl.ex_rd),
        .load_use    (load_use)
    );

    assign mispredict = ctl.ex_branch_valid && (ctl.ex_predict_jump != ctl.ex_actual_jump);
    assign mem_stall  = ctl.mem_req && !ctl.mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        apply_run   = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        redirect    = 1'b0;
        halted      = 1'b0;
        mem_timeout = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = '0;
                end else begin
                    apply_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                // completion wins over a timeout landing in the same cycle
                if (ctl.mem_ready) begin
                    apply_run = 1'b1;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    mem_timeout = 1'b1;
                    state_nxt   = HALT;
                    wait_nxt    = '0;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Shared RUN decision tree, also used on the cycle a memory wait completes
        if (apply_run) begin
            if (ctl.halt_req) begin
                state_nxt = HALT;
            end else begin
                state_nxt = RUN;
                if (mispredict) begin
                    // the ID instruction is squashed, so any load-use on it is moot
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    redirect    = 1'b1;
                end else if (load_use) begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (state != HALT) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Outputs are combinational in state, so force them quiet while reset is held
    assign ctl.pc_en        = pc_en       & rst;
    assign ctl.if_id_en     = if_id_en    & rst;
    assign ctl.id_ex_en     = id_ex_en    & rst;
    assign ctl.ex_mem_en    = ex_mem_en   & rst;
    assign ctl.mem_wb_en    = mem_wb_en   & rst;
    assign ctl.if_id_flush  = if_id_flush & rst;
    assign ctl.id_ex_flush  = id_ex_flush & rst;
    assign ctl.redirect     = redirect    & rst;
    assign ctl.halted       = halted      & rst;
    assign ctl.mem_timeout  = mem_timeout & rst;
    assign ctl.stall_cycles = stall_cnt;
    assign ctl.flush_count  = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand-built timeout and
// reset sequences, then random traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mrd;
        logic [4:0] rd;
        logic       bv;
        logic       pj;
        logic       aj;
        logic       mreq;
        logic       mrdy;
        logic       hreq;
    } in_t;

    typedef struct {
        in_t        i;
        logic [9:0] o;
        int         sc;
        int         fc;
    } vec_t;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, redirect, halted, timeout}
    localparam logic [9:0] ALL_O  = 10'b11111_00000;
    localparam logic [9:0] LU_O   = 10'b00111_01000;
    localparam logic [9:0] MISP_O = 10'b11111_11100;
    localparam logic [9:0] FRZ_O  = 10'b00000_00000;
    localparam logic [9:0] HALT_O = 10'b00000_00010;
    localparam logic [9:0] TMO_O  = 10'b00000_00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    bit m_wait, m_halt;
    int m_cnt, m_sc, m_fc;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_WIDTH(32)) bus ();
    pipeline_ctrl_if #(.CNT_WIDTH(3))  sbus ();

    pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_WIDTH(32)) dut (
        .clk (clk), .rst (rst), .ctl (bus.slave));

    pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_WIDTH(3)) dut_sat (
        .clk (clk), .rst (rst), .ctl (sbus.slave));

    assign sbus.id_rs1          = bus.id_rs1;
    assign sbus.id_rs2          = bus.id_rs2;
    assign sbus.id_rs1_used     = bus.id_rs1_used;
    assign sbus.id_rs2_used     = bus.id_rs2_used;
    assign sbus.ex_mem_read     = bus.ex_mem_read;
    assign sbus.ex_rd           = bus.ex_rd;
    assign sbus.ex_branch_valid = bus.ex_branch_valid;
    assign sbus.ex_predict_jump = bus.ex_predict_jump;
    assign sbus.ex_actual_jump  = bus.ex_actual_jump;
    assign sbus.mem_req         = bus.mem_req;
    assign sbus.mem_ready       = bus.mem_ready;
    assign sbus.halt_req        = bus.halt_req;

    function automatic in_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic mrd, logic [4:0] rd, logic bv, logic pj, logic aj,
                               logic mreq, logic mrdy, logic hreq);
        in_t v;
        v = '{rs1, rs2, u1, u2, mrd, rd, bv, pj, aj, mreq, mrdy, hreq};
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.rs1  = 5'($urandom_range(0, 3));
        v.rs2  = 5'($urandom_range(0, 3));
        v.u1   = 1'($urandom_range(0, 1));
        v.u2   = 1'($urandom_range(0, 1));
        v.mrd  = 1'($urandom_range(0, 1));
        v.rd   = 5'($urandom_range(0, 3));
        v.bv   = 1'($urandom_range(0, 1));
        v.pj   = 1'($urandom_range(0, 1));
        v.aj   = 1'($urandom_range(0, 1));
        v.mreq = ($urandom_range(0, 3) == 0);
        v.mrdy = 1'($urandom_range(0, 1));
        v.hreq = ($urandom_range(0, 40) == 0);
        return v;
    endfunction

    function automatic int sat7(int x);
        return (x > 7) ? 7 : x;
    endfunction

    task automatic apply(in_t v);
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_rs1_used     = v.u1;
        bus.id_rs2_used     = v.u2;
        bus.ex_mem_read     = v.mrd;
        bus.ex_rd           = v.rd;
        bus.ex_branch_valid = v.bv;
        bus.ex_predict_jump = v.pj;
        bus.ex_actual_jump  = v.aj;
        bus.mem_req         = v.mreq;
        bus.mem_ready       = v.mrdy;
        bus.halt_req        = v.hreq;
    endtask

    function automatic logic [9:0] outs();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.redirect, bus.halted, bus.mem_timeout};
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Reference model: expected outputs from the behavioural rules
    function automatic logic [9:0] model_out(in_t v);
        bit lu, misp, frozen;
        lu     = v.mrd && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        misp   = v.bv && (v.pj != v.aj);
        frozen = m_wait ? !v.mrdy : (v.mreq && !v.mrdy);
        if (m_halt)  return HALT_O;
        if (frozen)  return (m_wait && m_cnt == MAX_WAIT) ? TMO_O : FRZ_O;
        if (v.hreq)  return FRZ_O;
        if (misp)    return MISP_O;
        if (lu)      return LU_O;
        return ALL_O;
    endfunction

    task automatic model_step(in_t v, logic [9:0] o);
        if (!m_halt && !o[9]) m_sc++;
        if (o[2]) m_fc++;
        if (m_halt) return;
        if (o[0]) begin
            m_halt = 1'b1;
            m_wait = 1'b0;
        end else if (m_wait ? !v.mrdy : (v.mreq && !v.mrdy)) begin
            if (m_wait) m_cnt++;
            else begin
                m_wait = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            m_wait = 1'b0;
            if (v.hreq) m_halt = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_halt = 1'b0; m_cnt = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic do_reset(int idx);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst_out",   idx, 32'(outs()), 32'(FRZ_O));
        chk("rst_stall", idx, bus.stall_cycles, 0);
        chk("rst_flush", idx, bus.flush_count, 0);
        @(negedge clk);
        #1;
        chk("rst_hold",  idx, 32'(outs()), 32'(FRZ_O));
        rst = 1'b1;
        model_reset();
    endtask

    vec_t tbl[22];
    in_t  idle, mw, mr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mw   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        mr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        tbl[0]  = '{idle,                                    ALL_O,  0, 0};
        tbl[1]  = '{mk(5, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0), LU_O,   0, 0};
        tbl[2]  = '{idle,                                    ALL_O,  1, 0};
        tbl[3]  = '{mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), ALL_O,  1, 0};
        tbl[4]  = '{mk(3, 7, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0), ALL_O,  1, 0};
        tbl[5]  = '{mk(3, 7, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0), LU_O,   1, 0};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), MISP_O, 2, 0};
        tbl[7]  = '{mk(5, 0, 1, 0, 1, 5, 1, 0, 1, 0, 0, 0), MISP_O, 2, 1};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0), ALL_O,  2, 2};
        tbl[9]  = '{mw,                                      FRZ_O,  2, 2};
        tbl[10] = '{mw,                                      FRZ_O,  3, 2};
        tbl[11] = '{mw,                                      FRZ_O,  4, 2};
        tbl[12] = '{mr,                                      ALL_O,  5, 2};
        tbl[13] = '{idle,                                    ALL_O,  5, 2};
        tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), FRZ_O,  5, 2};
        tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), FRZ_O,  6, 2};
        tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0), MISP_O, 7, 2};
        tbl[17] = '{idle,                                    ALL_O,  7, 3};
        tbl[18] = '{mk(5, 0, 1, 0, 1, 5, 0, 0, 0, 1, 1, 0), LU_O,   7, 3};
        tbl[19] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), FRZ_O,  8, 3};
        tbl[20] = '{idle,                                    HALT_O, 9, 3};
        tbl[21] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), HALT_O, 9, 3};

        apply(idle);
        do_reset(0);

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i].i);
            #1;
            chk("vec_out",   i, 32'(outs()), 32'(tbl[i].o));
            chk("vec_stall", i, bus.stall_cycles, tbl[i].sc);
            chk("vec_flush", i, bus.flush_count, tbl[i].fc);
            chk("vec_sat",   i, 32'(sbus.stall_cycles), sat7(tbl[i].sc));
        end

        // Timeout: four counted wait cycles, a one-cycle pulse, then halted for good
        do_reset(1);
        for (int c = 0; c < 9; c++) begin
            logic [9:0] e;
            @(negedge clk);
            apply((c < 8) ? mw : mr);
            #1;
            e = (c < 5) ? FRZ_O : (c == 5) ? TMO_O : HALT_O;
            chk("tmo_out",   c, 32'(outs()), 32'(e));
            chk("tmo_stall", c, bus.stall_cycles, (c <= 5) ? c : 6);
        end

        // Asynchronous reset in the middle of a memory wait
        do_reset(2);
        repeat (3) begin
            @(negedge clk);
            apply(mw);
        end
        @(posedge clk);
        #1;
        chk("midrst_pre", 0, bus.stall_cycles, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out",   0, 32'(outs()), 32'(FRZ_O));
        chk("midrst_stall", 0, bus.stall_cycles, 0);
        @(negedge clk);
        apply(idle);
        #1;
        chk("midrst_hold", 0, 32'(outs()), 32'(FRZ_O));
        rst = 1'b1;
        #1;
        chk("midrst_run", 0, 32'(outs()), 32'(ALL_O));
        model_reset();
        model_step(idle, ALL_O);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            in_t        v;
            logic [9:0] e;
            v = rand_in();
            @(negedge clk);
            apply(v);
            #1;
            e = model_out(v);
            chk("rnd_out",       n, 32'(outs()), 32'(e));
            chk("rnd_stall",     n, bus.stall_cycles, m_sc);
            chk("rnd_flush",     n, bus.flush_count, m_fc);
            chk("rnd_sat_stall", n, 32'(sbus.stall_cycles), sat7(m_sc));
            chk("rnd_sat_flush", n, 32'(sbus.flush_count), sat7(m_fc));
            model_step(v, e);
            if (m_halt && $urandom_range(0, 3) == 0) do_reset(100 + n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the `en` and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. Its jobs:
- detect load-use hazards;
- recover from branch mispredictions resolved in EX;
- freeze the pipeline during multi-cycle data-memory accesses;
- halt on request.

It also keeps stall/flush performance counters.

## Interface
- `MAX_WAIT`, 16: data-memory wait cycles before timeout.
- `CNT_WIDTH`, 32: width of the performance counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  source actually read.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_branch_valid`  in  1  EX holds a resolved branch or jump.
- `ex_predict_jump`  in  1  prediction carried down from IF.
- `ex_actual_jump`  in  1  actual outcome.
- `mem_req`  in  1  MEM stage is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `halt_req`  in  1  ecall/halt instruction in EX.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register enables.
- `if_id_flush`, `id_ex_flush`  out  1 each  load zeros (bubble) on the next edge.
- `redirect`  out  1  PC mux selects the corrected target from EX.
- `halted`  out  1  in HALT.
- `mem_timeout`  out  1  one-cycle pulse on wait timeout.
- `stall_cycles`, `flush_count`  out  `CNT_WIDTH` each  performance counters.

## Operation
- States: RUN, MEM_WAIT, HALT. State is registered; outputs are a combinational function of state and inputs.
- Definitions:
  - mispredict = `ex_branch_valid & (ex_predict_jump != ex_actual_jump)`.
  - load_use = `ex_mem_read & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
  - mem_stall = `mem_req & ~mem_ready`.
- RUN, decisions in priority order:
  1. mem_stall: all enables 0, all flushes 0, redirect 0. Next state MEM_WAIT.
  2. halt_req: all enables 0. Next state HALT.
  3. mispredict: all enables 1, `if_id_flush`=`id_ex_flush`=1, `redirect`=1. Load_use is ignored because the ID instruction is squashed.
  4. load_use: `pc_en`=`if_id_en`=0, `id_ex_flush`=1 with `id_ex_en`=1, `ex_mem_en`=`mem_wb_en`=1.
  5. Otherwise: all enables 1, flushes 0.
- A flush is only ever asserted together with `en`=1 on the same register.
- MEM_WAIT:
  - `mem_ready`=0: everything frozen and the wait counter increments.
  - `mem_ready`=1: outputs are identical to RUN rules 2–5 for that cycle; next state RUN unless halt_req, in which case HALT.
  - When the wait counter reaches `MAX_WAIT`: `mem_timeout` pulses for one cycle, next state HALT.
  - The wait counter clears on entry to and exit from MEM_WAIT.
- HALT: all enables 0, flushes 0, `halted`=1. The only exit is reset.
- `stall_cycles` increments every cycle with `pc_en`=0 while not in HALT.
- `flush_count` increments on every cycle in which mispredict is acted upon.
- Both counters saturate at all-ones.

## Timing
- Reset (`rst`=0, asynchronous):
  - state RUN;
  - counters and wait counter 0;
  - all enables 0, flushes 0, `redirect`/`halted`/`mem_timeout` 0, held while `rst`=0.
- First edge after release: normal RUN behaviour.
- Zero-cycle decision latency: a hazard visible in cycle N drives enables/flushes in cycle N, and pipeline registers update at the end of N.
- Load-use costs exactly one bubble; on the next cycle the load has moved to MEM and load_use deasserts.
- Mispredict costs two bubbles (IF/ID and ID/EX squashed).
- A mispredict coincident with mem_stall is not lost: EX is frozen, so it is re-evaluated on the `mem_ready` cycle.
- Reset asserted mid-MEM_WAIT or in HALT: immediate return to the reset values.

## Structure
- Shared package/header `pipe_ctrl_pkg` holds:
  - state encodings: RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2;
  - the x0 register index constant.
- Sub-module `hazard_detect` (combinational) computes load_use; it is reused by the forwarding unit.
- The FSM, wait counter and performance counters live in `pipeline_ctrl`.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_rs1_used`=1 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; `stall_cycles`=1; normal flow after. Repeat with `ex_rd`=0 → no stall.
- **Mispredict:** `ex_branch_valid`=1, predict=1, actual=0 → `redirect`=1, both flushes=1, all enables=1; `flush_count`=1. Same cycle with load_use true → no `pc_en` stall.
- **Memory wait:** `mem_req`=1, `mem_ready` low for 3 cycles then high → 3 frozen cycles, release on the 4th; `stall_cycles`=3.
- **Mispredict during wait:** mispredict asserted during MEM_WAIT → no flush until the `mem_ready` cycle, then `redirect`/flush in that cycle.
- **Timeout:** `mem_ready` held 0 with `MAX_WAIT`=4 → `mem_timeout` pulse after 4 wait cycles, then `halted`=1 permanently.
- **Reset mid-operation:** `rst`=0 asynchronously during MEM_WAIT → outputs drop to reset values immediately; counters 0; RUN after release.
